// File: rtl/adder_scheduler.sv
// Round-robin scheduler that time-shares one adder macro among NREQ requesters,
// one transaction in flight. Define ADDER_SCHED_PERF_EN to add the perf_ops/perf_stall counters.
//   state | meaning
//   IDLE  | arbitrating; grants the round-robin winner and drives add_in
//   WAIT  | counting down the macro latency, captures result at terminal count
//   RESP  | holding the response until rsp_ready
module adder_scheduler #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 1,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [WIDTH-1:0]      add_in,
    input  logic [2*WIDTH-1:0]    add_out,
    input  logic                  add_carry,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic                  rsp_carry
`ifdef ADDER_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_stall
`endif
);

    localparam int CW = $clog2(ADD_LAT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    cnt;
    logic             found;
    logic [IDW-1:0]   gnt;
    logic [IDW:0]     idx_sum;
    logic [IDW:0]     ptr_sum;
    logic [IDW-1:0]   ptr_nxt;
    logic [WIDTH-1:0] gnt_data;

    // Ascending search starting at ptr, wrapping at NREQ (NREQ need not be a power of two)
    always_comb begin
        found   = 1'b0;
        gnt     = '0;
        idx_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (idx_sum >= (IDW+1)'(NREQ))
                idx_sum = idx_sum - (IDW+1)'(NREQ);
            if (!found && req_valid[idx_sum[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = idx_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        ptr_sum = {1'b0, gnt} + (IDW+1)'(1);
        ptr_nxt = ptr_sum[IDW-1:0];
        if (ptr_sum >= (IDW+1)'(NREQ))
            ptr_nxt = '0;
    end

    assign gnt_data = req_data[int'(gnt)*WIDTH +: WIDTH];

    // A grant is never advertised while reset is asserted, since it would not be taken
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && found && !rst)
            req_ready[gnt] = 1'b1;
    end

    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            add_in    <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        add_in <= gnt_data;
                        rsp_id <= gnt;
                        cnt    <= CW'(ADD_LAT - 1);
                        ptr    <= ptr_nxt;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        rsp_data  <= add_out;
                        rsp_carry <= add_carry;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADDER_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else if (state == ST_RESP) begin
            if (rsp_ready)
                perf_ops <= perf_ops + 32'd1;
            else
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Time-shares one dual-half adder macro datapath (`WIDTH`-bit operand in, `2*WIDTH`-bit result plus carry out) among `NREQ` requesters. Round-robin arbitration grants one requester at a time; the block drives the operand, waits the macro's fixed latency, captures the result and returns it with the requester index over a valid/ready response channel. The block sits between the requester-side logic and the adder macro instance, one transaction in flight at a time.

## Interface
- `WIDTH`, 16, operand width; result is `2*WIDTH`.
- `NREQ`, 4, number of requesters (2..16).
- `ADD_LAT`, 1, cycles from operand change to valid macro result/carry (1..8).
- `IDW`, `$clog2(NREQ)`, requester index width (derived, not overridden).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `req_data`  in  NREQ*WIDTH  operands; requester i at `[i*WIDTH +: WIDTH]`.
- `add_in`  out  WIDTH  operand to adder macro, registered.
- `add_out`  in  2*WIDTH  macro result.
- `add_carry`  in  1  macro carry.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  IDW  index of requester that owns the response.
- `rsp_data`  out  2*WIDTH  captured `add_out`.
- `rsp_carry`  out  1  captured `add_carry`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any `req_valid`, grant winner g: `req_ready[g]=1` combinationally this cycle, register `add_in <= req_data[g]`, `id <= g`, `cnt <= ADD_LAT-1`, go WAIT. No request: stay IDLE, `req_ready=0`.
- Round-robin: search starts at `ptr`, ascending with wrap; after grant `ptr <= (g+1) mod NREQ`. Non-requesting slots skipped.
- WAIT: `req_ready=0`. If `cnt==0`: capture `rsp_data <= add_out`, `rsp_carry <= add_carry`, go RESP; else `cnt <= cnt-1`.
- RESP: `rsp_valid=1`; `rsp_data`, `rsp_carry`, `rsp_id` stable until `rsp_ready`. On `rsp_valid && rsp_ready` go IDLE.
- `req_ready` is zero in WAIT and RESP; requests are never accepted while a transaction is in flight.
- `add_in` holds its last value outside a grant; no arithmetic inside this block.
- Requesters may drop `req_valid` before grant without side effect; `req_data` is sampled only in the grant cycle.

## Timing
- Reset values: state IDLE, `ptr=0`, `add_in=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rsp_carry=0`, `req_ready=0`.
- Grant at cycle T; `add_in` new value from T+1; result captured at end of T+ADD_LAT; `rsp_valid` high from T+ADD_LAT+1.
- Response accepted at cycle R; IDLE at R+1; next grant possible at R+1. Minimum issue interval: ADD_LAT+2 cycles.
- `rsp_ready` held high: response lasts exactly one cycle.
- `rst` in any state: transaction aborted, no response emitted, all registers to reset values next cycle; requester holding valid is re-arbitrated after reset.
- `rst` and `rsp_ready` in same cycle: reset wins.

## Configuration
- `ADDER_SCHED_PERF_EN` defined: adds output `perf_ops` (32 bits, counts completed response handshakes, wraps at 2^32) and `perf_stall` (32 bits, counts cycles in RESP with `rsp_ready=0`, wraps); both reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour identical.

## Test plan
- Single request, ADD_LAT=1, macro model each half = (2*in) mod 2^WIDTH, carry = both half carries: requester 2 sends 0x0003 at T -> `req_ready[2]` at T, `add_in=0x0003` at T+1, `rsp_valid` at T+2 with `rsp_data=0x00060006`, `rsp_carry=0`, `rsp_id=2`.
- Carry case: operand 0x8001 -> `rsp_data=0x00020002`, `rsp_carry=1`.
- All four requesters valid continuously, `rsp_ready=1` -> grant order 0,1,2,3,0; grants spaced ADD_LAT+2 cycles.
- Backpressure: `rsp_ready=0` for 5 cycles in RESP -> `rsp_*` stable, `req_ready` all zero, response accepted on cycle `rsp_ready` rises, no new grant before following cycle.
- Reset in WAIT (ADD_LAT=4, reset 2 cycles after grant) -> no `rsp_valid`, `ptr=0`, `add_in=0`; requester 1 still valid -> granted first cycle after reset released.
- With `ADDER_SCHED_PERF_EN`: 3 transactions, one stalled 4 cycles -> `perf_ops=3`, `perf_stall=4`.
